// File: rtl/cellnet_arbiter_pkg.sv
// cellnet_arbiter_pkg: shared sizes and arbiter state encoding for the cellnet arbiter.
//   ADDRESS_SIZE / DATA_SIZE : default cellnet address and data widths
//   arb_state_t              : 2-bit arbiter state (IDLE, SEND, RELAY, DRAIN)
package cellnet_arbiter_pkg;

   localparam int unsigned ADDRESS_SIZE = 8;
   localparam int unsigned DATA_SIZE    = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_SEND  = 2'd1,
      ARB_RELAY = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_t;

endpackage

// File: rtl/cellnet_rr_pick.sv
// cellnet_rr_pick: combinational rotated-priority search.
//   req     : request vector, one bit per source
//   ptr     : index with highest priority this round
//   valid_c : at least one request is present
//   idx_c   : first requesting index at or above ptr, wrapping at NSRC
module cellnet_rr_pick #(
   parameter int unsigned NSRC  = 4,
   parameter int unsigned IDXSZ = 2
) (
   input  logic [NSRC-1:0]  req,
   input  logic [IDXSZ-1:0] ptr,
   output logic             valid_c,
   output logic [IDXSZ-1:0] idx_c
);

   logic [2*NSRC-1:0] dbl;
   logic [NSRC-1:0]   rot;

   // (a + b) mod NSRC, with a < NSRC and b < NSRC
   function automatic logic [IDXSZ-1:0] wrap_add(input logic [IDXSZ-1:0] a, input int unsigned b);
      logic [IDXSZ:0] s;
      s = {1'b0, a} + (IDXSZ+1)'(b);
      if (s >= (IDXSZ+1)'(NSRC)) s = s - (IDXSZ+1)'(NSRC);
      return s[IDXSZ-1:0];
   endfunction

   // Rotate so bit 0 is the ptr source, then take the lowest set bit
   always_comb begin
      valid_c = 1'b0;
      idx_c   = '0;
      dbl     = {req, req};
      rot     = NSRC'(dbl >> ptr);
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid_c = 1'b1;
            idx_c   = wrap_add(ptr, i);
         end
      end
   end

endmodule

// File: rtl/cellnet_arbiter.sv
// cellnet_arbiter: round-robin share of one 4-phase cellnet sink among NSRC sources.
//   i_clk, i_rst_n             : clock, async active-low reset
//   i_src_addr/i_src_dat/req   : packed per-source requests (source k at [k*W +: W])
//   o_src_ack                  : ack relayed to the granted source only
//   o_snk_addr/dat/req, i_snk_ack : registered sink-side channel
//   o_grant_idx, o_busy, o_err : current/last grant, non-idle flag, sticky timeout flags
// Optional macro CELLNET_ARB_TIMEOUT_EN adds a SEND timeout that aborts into DRAIN
// and sets o_err[g]; without it o_err is constant 0.
module cellnet_arbiter
   import cellnet_arbiter_pkg::*;
#(
   parameter int unsigned NSRC    = 4,
   parameter int unsigned IDXSZ   = 2,
   parameter int unsigned ASZ     = ADDRESS_SIZE,
   parameter int unsigned DSZ     = DATA_SIZE,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NSRC*ASZ-1:0] i_src_addr,
   input  logic [NSRC*DSZ-1:0] i_src_dat,
   input  logic [NSRC-1:0]     i_src_req,
   output logic [NSRC-1:0]     o_src_ack,
   output logic [ASZ-1:0]      o_snk_addr,
   output logic [DSZ-1:0]      o_snk_dat,
   output logic                o_snk_req,
   input  logic                i_snk_ack,
   output logic [IDXSZ-1:0]    o_grant_idx,
   output logic                o_busy,
   output logic [NSRC-1:0]     o_err
);

   if (NSRC < 2 || NSRC > 16 || (1 << IDXSZ) < NSRC || TIMEOUT < 1) begin : g_param_check
      $error("cellnet_arbiter: illegal NSRC/IDXSZ/TIMEOUT combination");
   end

   arb_state_t       state;
   logic [IDXSZ-1:0] ptr;
   logic             pick_valid;
   logic [IDXSZ-1:0] pick_idx;

`ifdef CELLNET_ARB_TIMEOUT_EN
   localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
   logic [CNTW-1:0] cnt;
`else
   assign o_err = '0;
`endif

   cellnet_rr_pick #(.NSRC(NSRC), .IDXSZ(IDXSZ)) u_pick (
      .req     (i_src_req),
      .ptr     (ptr),
      .valid_c (pick_valid),
      .idx_c   (pick_idx)
   );

   // Arbiter FSM; all outputs registered here
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ARB_IDLE;
         ptr         <= '0;
         o_src_ack   <= '0;
         o_snk_addr  <= '0;
         o_snk_dat   <= '0;
         o_snk_req   <= 1'b0;
         o_grant_idx <= '0;
         o_busy      <= 1'b0;
`ifdef CELLNET_ARB_TIMEOUT_EN
         o_err       <= '0;
         cnt         <= '0;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  // Payload captured once; later source changes are ignored
                  o_snk_addr  <= i_src_addr[int'(pick_idx)*ASZ +: ASZ];
                  o_snk_dat   <= i_src_dat[int'(pick_idx)*DSZ +: DSZ];
                  o_grant_idx <= pick_idx;
                  o_snk_req   <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= ARB_SEND;
`ifdef CELLNET_ARB_TIMEOUT_EN
                  cnt         <= '0;
`endif
               end
            end
            ARB_SEND: begin
               // A source dropping req here is ignored; only the sink ends SEND
               if (i_snk_ack) begin
                  o_src_ack[o_grant_idx] <= 1'b1;
                  state                  <= ARB_RELAY;
`ifdef CELLNET_ARB_TIMEOUT_EN
               end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                  o_err[o_grant_idx] <= 1'b1;
                  o_snk_req          <= 1'b0;
                  state              <= ARB_DRAIN;
               end else begin
                  cnt <= cnt + CNTW'(1);
`endif
               end
            end
            ARB_RELAY: begin
               if (!i_src_req[o_grant_idx]) begin
                  o_snk_req <= 1'b0;
                  state     <= ARB_DRAIN;
               end
            end
            ARB_DRAIN: begin
               if (!i_snk_ack) begin
                  o_src_ack <= '0;
                  o_busy    <= 1'b0;
                  ptr       <= (o_grant_idx == IDXSZ'(NSRC - 1)) ? '0 : o_grant_idx + IDXSZ'(1);
                  state     <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cellnet_arbiter.sv
// tb_cellnet_arbiter: directed plus randomized bench for cellnet_arbiter with a
// behavioural round-robin reference model and a task-driven sink/source handshake.
module tb_cellnet_arbiter;

   localparam int unsigned NSRC = 4;
   localparam int unsigned ASZ  = 8;
   localparam int unsigned DSZ  = 8;
   localparam int unsigned TMO  = 8;

   logic                clk;
   logic                rst_n;
   logic [NSRC*ASZ-1:0] src_addr_bus;
   logic [NSRC*DSZ-1:0] src_dat_bus;
   logic [NSRC-1:0]     s_req;
   logic [NSRC-1:0]     src_ack;
   logic [ASZ-1:0]      snk_addr;
   logic [DSZ-1:0]      snk_dat;
   logic                snk_req;
   logic                snk_ack;
   logic [1:0]          grant_idx;
   logic                busy;
   logic [NSRC-1:0]     err;

   logic [ASZ-1:0] s_addr [NSRC];
   logic [DSZ-1:0] s_dat  [NSRC];

   int checks;
   int errors;
   int ptr_m;

   cellnet_arbiter #(.NSRC(NSRC), .IDXSZ(2), .ASZ(ASZ), .DSZ(DSZ), .TIMEOUT(TMO)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_src_addr  (src_addr_bus),
      .i_src_dat   (src_dat_bus),
      .i_src_req   (s_req),
      .o_src_ack   (src_ack),
      .o_snk_addr  (snk_addr),
      .o_snk_dat   (snk_dat),
      .o_snk_req   (snk_req),
      .i_snk_ack   (snk_ack),
      .o_grant_idx (grant_idx),
      .o_busy      (busy),
      .o_err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      src_addr_bus = '0;
      src_dat_bus  = '0;
      for (int k = 0; k < NSRC; k++) begin
         src_addr_bus[k*ASZ +: ASZ] = s_addr[k];
         src_dat_bus[k*DSZ +: DSZ]  = s_dat[k];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester at or after p, wrapping
   function automatic int model_pick(input int p, input logic [NSRC-1:0] rq);
      for (int off = 0; off < NSRC; off++)
         if (rq[(p + off) % NSRC]) return (p + off) % NSRC;
      return -1;
   endfunction

   task automatic wait_grant(output int lat);
      lat = 0;
      while (!snk_req && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk("grant_wait", 32'(snk_req), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_snk_req"}, 32'(snk_req), 32'd0);
      chk({tag, "_snk_addr"}, 32'(snk_addr), 32'd0);
      chk({tag, "_snk_dat"}, 32'(snk_dat), 32'd0);
      chk({tag, "_src_ack"}, 32'(src_ack), 32'd0);
      chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // One full 4-phase transaction; sink acks d cycles after seeing req
   task automatic serve(input int d, input bit requeue, output int g, output int lat);
      logic [ASZ-1:0] ea;
      logic [DSZ-1:0] ed;
      g  = model_pick(ptr_m, s_req);
      ea = s_addr[g];
      ed = s_dat[g];
      wait_grant(lat);
      chk("grant_idx", 32'(grant_idx), 32'(g));
      chk("snk_addr", 32'(snk_addr), 32'(ea));
      chk("snk_dat", 32'(snk_dat), 32'(ed));
      chk("busy_send", 32'(busy), 32'd1);
      chk("ack_early", 32'(src_ack), 32'd0);
      // Source misbehaves by changing payload after grant
      s_addr[g] = s_addr[g] ^ 8'hFF;
      s_dat[g]  = s_dat[g] + 8'd2;
      for (int i = 0; i < d; i++) begin
         @(negedge clk);
         chk("wait_snk_req", 32'(snk_req), 32'd1);
         chk("wait_src_ack", 32'(src_ack), 32'd0);
      end
      snk_ack = 1'b1;
      @(negedge clk);
      chk("relay_ack", 32'(src_ack), 32'(1) << g);
      chk("hold_dat", 32'(snk_dat), 32'(ed));
      s_req[g] = 1'b0;
      @(negedge clk);
      chk("drain_snk_req", 32'(snk_req), 32'd0);
      chk("drain_ack", 32'(src_ack), 32'(1) << g);
      snk_ack = 1'b0;
      if (requeue) begin
         s_addr[g] = 8'($urandom);
         s_dat[g]  = 8'($urandom);
         s_req[g]  = 1'b1;
      end
      @(negedge clk);
      chk("idle_ack", 32'(src_ack), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      ptr_m = (g + 1) % NSRC;
   endtask

   initial begin
      int g;
      int lat;
      int order_exp [5];
      checks  = 0;
      errors  = 0;
      ptr_m   = 0;
      order_exp = '{0, 1, 2, 3, 0};
      rst_n   = 1'b0;
      snk_ack = 1'b0;
      s_req   = '0;
      for (int k = 0; k < NSRC; k++) begin
         s_addr[k] = '0;
         s_dat[k]  = '0;
      end
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Single request from source 1
      s_addr[1] = 8'd1;
      s_dat[1]  = 8'd5;
      s_req[1]  = 1'b1;
      serve(1, 1'b0, g, lat);
      chk("single_latency", 32'(lat), 32'd1);
      chk("single_grant", 32'(grant_idx), 32'd1);
      chk("single_dat", 32'(snk_dat), 32'd5);
      chk("single_err", 32'(err), 32'd0);

      // All four from reset, each re-requesting at once
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      for (int k = 0; k < NSRC; k++) begin
         s_addr[k] = 8'(16 + k);
         s_dat[k]  = 8'(32 + k);
      end
      s_req = '1;
      for (int i = 0; i < 5; i++) begin
         serve(1, 1'b1, g, lat);
         chk("rr_order", 32'(grant_idx), 32'(order_exp[i]));
      end
      s_req = '0;

      // Payload hold: source 2 changes dat 7 -> 9 during SEND
      s_addr[2] = 8'd2;
      s_dat[2]  = 8'd7;
      s_req[2]  = 1'b1;
      serve(2, 1'b0, g, lat);
      chk("hold_final_dat", 32'(snk_dat), 32'd7);

      // Slow sink
      s_addr[3] = 8'd3;
      s_dat[3]  = 8'hA5;
      s_req[3]  = 1'b1;
      serve(20, 1'b0, g, lat);

      // Randomized traffic against the round-robin model
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < NSRC; k++) begin
            if (!s_req[k] && $urandom_range(0, 1) == 1) begin
               s_addr[k] = 8'($urandom);
               s_dat[k]  = 8'($urandom);
               s_req[k]  = 1'b1;
            end
         end
         if (s_req == '0) begin
            s_addr[0] = 8'($urandom);
            s_dat[0]  = 8'($urandom);
            s_req[0]  = 1'b1;
         end
         serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), g, lat);
      end
      s_req = '0;

`ifdef CELLNET_ARB_TIMEOUT_EN
      // No sink answers address 3: abort after TMO cycles
      s_addr[2] = 8'd3;
      s_dat[2]  = 8'd1;
      s_req[2]  = 1'b1;
      g = model_pick(ptr_m, s_req);
      wait_grant(lat);
      chk("tmo_grant", 32'(grant_idx), 32'(g));
      for (int i = 0; i < int'(TMO); i++) begin
         chk("tmo_snk_req", 32'(snk_req), 32'd1);
         chk("tmo_src_ack", 32'(src_ack), 32'd0);
         @(negedge clk);
      end
      chk("tmo_drop", 32'(snk_req), 32'd0);
      chk("tmo_err", 32'(err), 32'(1) << g);
      chk("tmo_no_ack", 32'(src_ack), 32'd0);
      s_req[g] = 1'b0;
      @(negedge clk);
      chk("tmo_idle", 32'(busy), 32'd0);
      ptr_m = (g + 1) % NSRC;
      s_addr[3] = 8'd4;
      s_dat[3]  = 8'd6;
      s_req[3]  = 1'b1;
      serve(1, 1'b0, g, lat);
      chk("tmo_err_sticky", 32'(err[2]), 32'd1);
      s_req = '0;
`else
      chk("err_tied", 32'(err), 32'd0);
`endif

      // Reset in RELAY: serve src0 so ptr moves, then abort src1 mid-transaction
      s_req[0] = 1'b1;
      serve(1, 1'b0, g, lat);
      s_addr[1] = 8'h11;
      s_dat[1]  = 8'h22;
      s_req[1]  = 1'b1;
      wait_grant(lat);
      snk_ack = 1'b1;
      @(negedge clk);
      chk("pre_rst_ack", 32'(src_ack), 32'd2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      snk_ack = 1'b0;
      s_req   = '0;
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      s_addr[0] = 8'h44;
      s_dat[0]  = 8'h55;
      s_addr[3] = 8'h66;
      s_dat[3]  = 8'h77;
      s_req     = 4'b1001;
      serve(1, 1'b0, g, lat);
      chk("post_rst_grant", 32'(grant_idx), 32'd0);
      s_req = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cellnet_arbiter.md
Name: cellnet_arbiter

Overview:
- Shares one cellnet sink channel (addr/dat/req/ack, 4-phase) between NSRC source requesters.
- Round-robin grant; one complete 4-phase transaction per grant.
- Sits between several cellnet sources and a single cellnet_sink instance or sink bus segment. It relays the sink ack back to the granted source only.

Parameters:
- NSRC, 4: number of source requesters (2..16).
- IDXSZ, 2: width of the grant index; must satisfy 2**IDXSZ >= NSRC.
- ASZ, `ADDRESS_SIZE: address width.
- DSZ, `DATA_SIZE: data width.
- TIMEOUT, 255: cycles to wait for sink ack before abort. Used only with CELLNET_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  main clock (25 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_src_addr  in  NSRC*ASZ  source addresses; source k occupies bits [k*ASZ +: ASZ].
- i_src_dat  in  NSRC*DSZ  source data; source k occupies bits [k*DSZ +: DSZ].
- i_src_req  in  NSRC  per-source request.
- o_src_ack  out  NSRC  per-source ack; at most one bit high at a time.
- o_snk_addr  out  ASZ  registered address to sink.
- o_snk_dat  out  DSZ  registered data to sink.
- o_snk_req  out  1  registered request to sink.
- i_snk_ack  in  1  sink ack.
- o_grant_idx  out  IDXSZ  index of the current or last granted source.
- o_busy  out  1  high in any state other than IDLE.
- o_err  out  NSRC  sticky per-source timeout flag. Tied to 0 without the macro.

Behaviour:
- Reset (async assert, sync release):
  - o_snk_req=0, o_snk_addr=0, o_snk_dat=0.
  - o_src_ack=0, o_grant_idx=0, o_err=0, o_busy=0.
  - Round-robin pointer = 0; state = IDLE.
- States: IDLE, SEND, RELAY, DRAIN.
- IDLE:
  - If any i_src_req is high, pick the first requesting index searching from ptr upward with wrap.
  - Next edge: latch that source's addr/dat into o_snk_addr/o_snk_dat, set o_grant_idx, o_snk_req=1, go to SEND.
  - Grant latency from req seen to o_snk_req high: 1 cycle.
- SEND:
  - Wait for i_snk_ack=1.
  - Then set o_src_ack[g]=1 and go to RELAY.
- RELAY:
  - Wait for i_src_req[g]=0.
  - Then set o_snk_req=0 and go to DRAIN.
- DRAIN:
  - Wait for i_snk_ack=0.
  - Then set o_src_ack[g]=0, ptr=(g+1) wrapped at NSRC, and go to IDLE.
- Data and address are captured once at grant. Source changes after grant are ignored.
- Other sources' requests are held pending during a transaction; they are never acked early.
- A source that keeps req high across IDLE is re-eligible only after every other pending source is served (fairness).
- An i_src_req[g] drop while in SEND is illegal source behaviour: the arbiter keeps waiting for sink ack (no abort).
- Minimum cycles per transaction with an immediate sink: 5 (IDLE→SEND→RELAY→DRAIN→IDLE plus the sink's registered ack).
- Reset mid-transaction: all outputs return to reset values immediately; sink state is the sink's own concern.
- NSRC bits of i_src_req above NSRC-1 do not exist; o_grant_idx never exceeds NSRC-1.

Optional Feature:
- Macro: CELLNET_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in SEND and clears on entry.
  - When the count reaches TIMEOUT without i_snk_ack, set o_err[g] (sticky until reset), drop o_snk_req, and go to DRAIN with o_src_ack[g] left at 0.
  - DRAIN then exits on i_snk_ack=0 as normal and advances ptr. This covers an unmatched address at the sink.
- Without the macro: no counter; SEND waits indefinitely; o_err is constant 0.

Decomposition:
- Shared header hglobal.v:
  - `ADDRESS_SIZE, `DATA_SIZE, `ON/`OFF.
  - New state encodings `CELLNET_ARB_IDLE, `CELLNET_ARB_SEND, `CELLNET_ARB_RELAY, `CELLNET_ARB_DRAIN (2 bits).
- One sub-module, cellnet_rr_pick (combinational):
  - Inputs: req vector and ptr. Outputs: valid and index.
  - Rotated priority search, instantiated once.

Test Plan:
- Single request: src1 req with addr=1, dat=5 to a cellnet_sink with LOCAL_ADDR=1 → o_snk_req high 1 cycle after req; o_src_ack[1] rises after sink ack; sink o_dat=5; o_grant_idx=1; o_err=0.
- Simultaneous requests: src0..3 all requesting from reset → grant order 0,1,2,3. With src0 re-requesting immediately the order continues 0,1,2,3,0, never 0,0.
- Data hold: src2 changes dat from 7 to 9 while in SEND → sink receives 7. Only o_src_ack[2] ever goes high.
- Slow sink: ack delayed 20 cycles → o_src_ack stays 0 and o_snk_req stays 1 throughout; the full 4-phase then completes and o_busy falls in IDLE.
- Timeout (macro on, TIMEOUT=8): addr=3 with no matching sink → after 8 cycles o_err[g]=1, o_snk_req=0, o_src_ack[g] never high; the next source is granted afterwards.
- Async reset asserted in RELAY → all outputs 0 in the same cycle; after release the first request is granted from index 0.
